// File: rtl/traffic_pkg.sv
// Shared types and helpers for the four-way traffic light controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

  // Direction codes, also the bit index into per-direction vectors.
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV enabled cycles.
// Latency: tick is high during the cycle the count sits at TICK_DIV-1.
// Backpressure: enable low freezes the count and suppresses tick.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = cnt_width(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Count 0..TICK_DIV-1 while enabled, wrapping on the tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Round-robin four-way intersection sequencer: ALL_RED -> GREEN -> YELLOW per direction.
// Latency: lamps/phase/active_dir registered, updated on the same edge as the state change.
// Backpressure: enable low holds prescaler, timer and FSM. Option: TRAFFIC_SENSOR_SKIP_EN.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int TICK_DIV      = 25_000_000,
  parameter int GREEN_TICKS   = 5,
  parameter int YELLOW_TICKS  = 2,
  parameter int ALL_RED_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  output logic       N_red,
  output logic       N_yellow,
  output logic       N_green,
  output logic       E_red,
  output logic       E_yellow,
  output logic       E_green,
  output logic       S_red,
  output logic       S_yellow,
  output logic       S_green,
  output logic       W_red,
  output logic       W_yellow,
  output logic       W_green,
  output logic [1:0] active_dir,
  output logic [1:0] phase
);

  localparam int GY_MAX    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int TICKS_MAX = (GY_MAX > ALL_RED_TICKS) ? GY_MAX : ALL_RED_TICKS;
  localparam int TW        = cnt_width(TICKS_MAX - 1);

  localparam logic [TW-1:0] T_GREEN   = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] T_YELLOW  = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] T_ALL_RED = TW'(ALL_RED_TICKS - 1);

  logic          tick;
  phase_e        phase_q, phase_d;
  logic [1:0]    dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    red_q, red_d;
  logic [3:0]    yel_q, yel_d;
  logic [3:0]    grn_q, grn_d;
  logic [1:0]    next_dir;
  logic          next_ok;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

`ifdef TRAFFIC_SENSOR_SKIP_EN
  logic [3:0] pend_q, pend_d;

  // Request latch: a new request wins over the clear on green entry.
  always_comb begin
    pend_d = pend_q;
    if (phase_d == PH_GREEN && phase_q != PH_GREEN) begin
      pend_d[dir_d] = 1'b0;
    end
    pend_d = pend_d | req;
  end

  // Request latch register; runs even while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Pick the first pending direction after the current one; own direction is checked last.
  always_comb begin
    next_dir = dir_q;
    next_ok  = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (pend_q[dir_q + 2'(i)]) begin
        next_dir = dir_q + 2'(i);
        next_ok  = 1'b1;
      end
    end
  end
`else
  logic unused_req;
  assign unused_req = ^req;

  // Fixed N -> E -> S -> W rotation.
  always_comb begin
    next_dir = dir_q + 2'd1;
    next_ok  = 1'b1;
  end
`endif

  // Next-state: phase timer counts ticks down; phase advances on the tick where it reaches zero.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    if (tick) begin
      if (timer_q == '0) begin
        case (phase_q)
          PH_ALL_RED: begin
            if (next_ok) begin
              phase_d = PH_GREEN;
              dir_d   = next_dir;
              timer_d = T_GREEN;
            end else begin
              timer_d = T_ALL_RED;
            end
          end
          PH_GREEN: begin
            phase_d = PH_YELLOW;
            timer_d = T_YELLOW;
          end
          PH_YELLOW: begin
            phase_d = PH_ALL_RED;
            timer_d = T_ALL_RED;
          end
          default: begin
            phase_d = PH_ALL_RED;
            timer_d = T_ALL_RED;
          end
        endcase
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  // Lamp decode from the next state so lamps register on the same edge as the phase.
  always_comb begin
    red_d = 4'hF;
    yel_d = 4'h0;
    grn_d = 4'h0;
    case (phase_d)
      PH_GREEN: begin
        red_d[dir_d] = 1'b0;
        grn_d[dir_d] = 1'b1;
      end
      PH_YELLOW: begin
        red_d[dir_d] = 1'b0;
        yel_d[dir_d] = 1'b1;
      end
      default: begin
        red_d = 4'hF;
      end
    endcase
  end

  // State, timer and lamp registers; reset makes W the last served so N goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_ALL_RED;
      dir_q   <= DIR_W;
      timer_q <= T_ALL_RED;
      red_q   <= 4'hF;
      yel_q   <= 4'h0;
      grn_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
    end
  end

  assign N_red    = red_q[DIR_N];
  assign N_yellow = yel_q[DIR_N];
  assign N_green  = grn_q[DIR_N];
  assign E_red    = red_q[DIR_E];
  assign E_yellow = yel_q[DIR_E];
  assign E_green  = grn_q[DIR_E];
  assign S_red    = red_q[DIR_S];
  assign S_yellow = yel_q[DIR_S];
  assign S_green  = grn_q[DIR_S];
  assign W_red    = red_q[DIR_W];
  assign W_yellow = yel_q[DIR_W];
  assign W_green  = grn_q[DIR_W];

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller (TICK_DIV=4, G=3, Y=2, AR=1).
// Expected state comes from elapsed enabled cycles: 4 all-red, 12 green, 8 yellow per direction.
// Sensor-skip sequences run when TRAFFIC_SENSOR_SKIP_EN is defined.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic N_red, N_yellow, N_green, E_red, E_yellow, E_green;
  logic S_red, S_yellow, S_green, W_red, W_yellow, W_green;
  logic [1:0] active_dir, phase;

  int errors = 0;
  int checks = 0;
  int e      = 0;   // enabled clock edges since reset release

  always #5 clk = ~clk;

  traffic_light_controller #(
    .TICK_DIV      (4),
    .GREEN_TICKS   (3),
    .YELLOW_TICKS  (2),
    .ALL_RED_TICKS (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .N_red      (N_red),
    .N_yellow   (N_yellow),
    .N_green    (N_green),
    .E_red      (E_red),
    .E_yellow   (E_yellow),
    .E_green    (E_green),
    .S_red      (S_red),
    .S_yellow   (S_yellow),
    .S_green    (S_green),
    .W_red      (W_red),
    .W_yellow   (W_yellow),
    .W_green    (W_green),
    .active_dir (active_dir),
    .phase      (phase)
  );

  wire [11:0] lamps_act = {W_green, W_yellow, W_red, S_green, S_yellow, S_red,
                           E_green, E_yellow, E_red, N_green, N_yellow, N_red};

  // Lamp pattern for a phase (0 AR, 1 G, 2 Y) and served direction; 3 bits {g,y,r} per direction.
  function automatic logic [11:0] lamps_of(input int ph, input int dir);
    logic [11:0] l;
    for (int d = 0; d < 4; d++) begin
      l[3*d]   = !(ph != 0 && dir == d);
      l[3*d+1] = (ph == 2 && dir == d);
      l[3*d+2] = (ph == 1 && dir == d);
    end
    return l;
  endfunction

  // Fixed-rotation reference: position within a 96-cycle round of four 24-cycle slots.
  task automatic model(input int ee, output int ph, output int dir);
    int p, idx, r;
    p   = ee % 96;
    idx = p / 24;
    r   = p % 24;
    if (r < 4) begin
      ph  = 0;
      dir = (idx + 3) % 4;
    end else if (r < 16) begin
      ph  = 1;
      dir = idx;
    end else begin
      ph  = 2;
      dir = idx;
    end
  endtask

  task automatic check_state(input string name, input int ph, input int dir);
    logic [15:0] exp_v, act_v;
    exp_v = {lamps_of(ph, dir), 2'(dir), 2'(ph)};
    act_v = {lamps_act, active_dir, phase};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s (e=%0d): got lamps=%b dir=%0d phase=%0d, want lamps=%b dir=%0d phase=%0d",
               name, e, lamps_act, active_dir, phase, exp_v[15:4], dir, ph);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  // Reset ends on a falling edge with no rising edge seen since release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  // Advance n clock cycles, sampling point stays on the falling edge.
  task automatic run(input int n);
    repeat (n) begin
      if (enable) e++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int delta;
    int ph;
    int dir;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int ph, dir, gcnt, ycnt, cyc;
    rst_n  = 1'b0;
    enable = 1'b1;
    req    = 4'b0;

`ifndef TRAFFIC_SENSOR_SKIP_EN
    // Enabled-cycle deltas with the expected state after each one (one full round plus wrap).
    tbl[0]  = '{0, 0, 3};   tbl[1]  = '{3, 0, 3};   tbl[2]  = '{1, 1, 0};
    tbl[3]  = '{11, 1, 0};  tbl[4]  = '{1, 2, 0};   tbl[5]  = '{7, 2, 0};
    tbl[6]  = '{1, 0, 0};   tbl[7]  = '{3, 0, 0};   tbl[8]  = '{1, 1, 1};
    tbl[9]  = '{12, 2, 1};  tbl[10] = '{8, 0, 1};   tbl[11] = '{4, 1, 2};
    tbl[12] = '{12, 2, 2};  tbl[13] = '{8, 0, 2};   tbl[14] = '{4, 1, 3};
    tbl[15] = '{12, 2, 3};  tbl[16] = '{8, 0, 3};   tbl[17] = '{3, 0, 3};
    tbl[18] = '{1, 1, 0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      run(tbl[i].delta);
      check_state($sformatf("vec%0d", i), tbl[i].ph, tbl[i].dir);
    end

    // Asynchronous reset in the middle of E yellow, observed with no clock edge.
    do_reset();
    run(42);
    check_state("pre_async_e_yellow", 2, 1);
    #2 rst_n = 1'b0;
    #1 check_state("async_reset", 0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    run(4);
    check_state("after_async_first_n", 1, 0);

    // Enable dropped for 10 cycles inside N green stretches green only.
    do_reset();
    gcnt = 0;
    ycnt = 0;
    cyc  = 0;
    while (!(ycnt > 0 && !N_yellow) && cyc < 200) begin
      if (N_green) gcnt++;
      if (N_yellow) ycnt++;
      enable = !(cyc >= 9 && cyc < 19);
      @(negedge clk);
      cyc++;
    end
    enable = 1'b1;
    check_val("enable_timeout", (cyc < 200) ? 1 : 0, 1);
    check_val("n_green_len", gcnt, 22);
    check_val("n_yellow_len", ycnt, 8);

    // Random enable and request traffic against the elapsed-cycle model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      model(e, ph, dir);
      check_state("rand", ph, dir);
      enable = ($urandom_range(0, 3) != 0);
      req    = 4'($urandom);
      run(1);
    end
    enable = 1'b1;
    req    = 4'b0;
`else
    // No requests: stays all red with W as last served.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run(10);
      check_state("idle_all_red", 0, 3);
    end

    // One-cycle S request: N and E skipped, S served once, then idle.
    do_reset();
    req = 4'b0100;
    run(1);
    req = 4'b0000;
    run(3);
    check_state("skip_to_s", 1, 2);
    check_val("pend_s_cleared", int'(dut.pend_q[2]), 0);
    run(12);
    check_state("s_yellow", 2, 2);
    run(8);
    check_state("s_all_red", 0, 2);
    run(4);
    check_state("s_no_pend_hold", 0, 2);
    run(12);
    check_state("s_no_pend_hold2", 0, 2);

    // N held through its green: N re-served after E, S, W are skipped.
    do_reset();
    req = 4'b0001;
    run(4);
    check_state("n_first", 1, 0);
    run(12);
    check_state("n_yellow", 2, 0);
    req = 4'b0000;
    run(8);
    check_state("n_all_red", 0, 0);
    run(4);
    check_state("n_again", 1, 0);
    run(12);
    check_state("n_again_yellow", 2, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
